apb_median_filter_stream: RTL and testbench
===========================================

Name: apb_median_filter_stream

Overview:
APB4 slave implementing a parametrised sliding-window median filter over a stream of unsigned samples written by the CPU. A window of WIN_SIZE samples is re-sorted after every write by a multi-cycle odd-even transposition sorter, which exposes median, min and max. Adds control/status, a clear operation, APB back-pressure while sorting, and a completion interrupt.

Parameters:
BUS_WIDTH, 32, APB data width (fixed 32 in this generation)
SAMPLE_W, 8, sample width in bits, 1..32; unsigned compare
WIN_SIZE, 9, window length, odd, 3..31

Ports:
S_CLK  in  1  clock
S_RST  in  1  reset, asynchronous, active-high
S_PSEL  in  1  APB select
S_PENABLE  in  1  APB enable
S_PADDR  in  32  byte address; only [7:0] decoded
S_PWRITE  in  1  1=write
S_PWDATA  in  BUS_WIDTH  write data
S_PREADY  out  1  transfer complete
S_PSLVERR  out  1  transfer error, valid with S_PREADY
S_PRDATA  out  BUS_WIDTH  read data
IRQ  out  1  level interrupt = IRQ_EN & DONE flag

Behaviour:
- One clock (S_CLK), asynchronous active-high reset (S_RST). Reset: window, scratch, fill, CTRL, results, DONE = 0; FSM IDLE; S_PREADY=0, S_PSLVERR=0, S_PRDATA=0, IRQ=0.
- Transfer completes in the access cycle (S_PSEL & S_PENABLE) in which S_PREADY=1; side effects on that clock edge only. S_PREADY combinational: 1 in every access cycle except a DATA_IN write while FSM != IDLE (held 0 until IDLE). Outside access cycles S_PREADY=0, S_PSLVERR=0, S_PRDATA=0.
- Register map (addr[7:0]):
  0x00 CTRL RW: [0] EN, [1] IRQ_EN, [2] CLR (write-1 pulse, reads 0).
  0x04 STATUS RO: [0] BUSY, [1] VALID, [2] DONE, [15:8] FILL.
  0x08 DATA_IN RW: write shifts PWDATA[SAMPLE_W-1:0] into window, oldest discarded; read returns newest sample, zero-extended.
  0x0C MEDIAN RO, 0x10 MIN RO, 0x14 MAX RO: results of last completed sort, zero-extended.
  0x18 IRQ_STAT: [0] DONE, write-1-to-clear.
  0x1C INFO RO: [15:8] WIN_SIZE, [7:0] SAMPLE_W.
- Errors: unmapped address, or write to RO register (0x04, 0x0C-0x14, 0x1C) -> S_PSLVERR=1 with S_PREADY=1, no state change, PRDATA=0.
- FILL increments per DATA_IN write, saturates at WIN_SIZE.
- FSM IDLE/SORT. In IDLE, an accepted DATA_IN write with EN=1 and post-write FILL==WIN_SIZE copies the post-write window into scratch and enters SORT. With EN=0 samples still shift and FILL counts; no sort.
- SORT: one compare-exchange pass per cycle, passes 0..WIN_SIZE-1, even passes pair (0,1),(2,3)..., odd passes pair (1,2),(3,4)...; ascending. On the edge ending pass WIN_SIZE-1: MEDIAN=scratch[WIN_SIZE/2], MIN=scratch[0], MAX=scratch[WIN_SIZE-1], VALID=1, DONE=1, FSM->IDLE.
- BUSY=1 exactly WIN_SIZE cycles, starting the cycle after the accepting edge. Stalled DATA_IN write completes in the first IDLE cycle (S_PREADY=1) and may start the next sort immediately.
- CLR: FILL=0, window=0, VALID=0, aborts SORT to IDLE without updating results or DONE; results keep old values. CLR write also updates EN/IRQ_EN from the same write.
- DONE set and W1C on the same edge: set wins.
- Reset mid-sort: immediate return to reset state.

Test Plan:
- Reset, read 0x1C -> 0x0000_0908; read 0x04 -> 0; IRQ=0, S_PREADY=0 outside access.
- CTRL=0x3; write 5,1,9,3,7,2,8,6,4 to 0x08 -> BUSY high 9 cycles after 9th write; MEDIAN=5, MIN=1, MAX=9, STATUS=0x0906, IRQ=1; write 1 to 0x18 -> IRQ=0.
- Then write 0xFF -> window 1,9,3,7,2,8,6,4,255 -> MEDIAN=6, MIN=1, MAX=255; second DATA_IN write issued 1 cycle after -> S_PREADY low 8 access cycles, then completes.
- Write 0x0C -> S_PSLVERR=1, MEDIAN unchanged; read 0x20 -> S_PSLVERR=1, PRDATA=0.
- Start sort, write CTRL=0x7 at pass 3 -> BUSY=0 next cycle, FILL=0, VALID=0, DONE unchanged, results unchanged; nine writes of 0x42 -> MEDIAN=MIN=MAX=0x42.
- Assert S_RST during SORT -> all outputs and STATUS 0 asynchronously; EN=0 then 9 writes -> FILL=9, BUSY never asserts.

Source files
------------

// File: rtl/apb_median_filter_stream.sv
// APB4 slave: sliding-window median/min/max filter over CPU-written samples.
// The window is re-sorted after each write by a one-pass-per-cycle odd-even transposition sorter.
module apb_median_filter_stream #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned WIN_SIZE  = 9
) (
  input  logic                 S_CLK,
  input  logic                 S_RST,
  input  logic                 S_PSEL,
  input  logic                 S_PENABLE,
  input  logic [31:0]          S_PADDR,
  input  logic                 S_PWRITE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic                 S_PREADY,
  output logic                 S_PSLVERR,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 IRQ
);

  localparam int unsigned PassW = $clog2(WIN_SIZE);

  typedef enum logic {StIdle, StSort} state_e;
  typedef logic [SAMPLE_W-1:0] sample_t;

  state_e           state_q;
  sample_t          window_q  [WIN_SIZE];
  sample_t          scratch_q [WIN_SIZE];
  sample_t          window_sh [WIN_SIZE];
  sample_t          pass_out  [WIN_SIZE];
  logic [PassW-1:0] pass_q;
  logic [7:0]       fill_q, fill_post;
  logic             en_q, irq_en_q, valid_q, done_q, done_d;
  sample_t          median_q, min_q, max_q;

  logic [7:0]           addr;
  logic                 access, stall, xfer, mapped, ro, err, wr_ok;
  logic                 ctrl_wr, data_wr, w1c_wr, clr, start_sort, last_pass;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 unused_bits;

  assign addr        = S_PADDR[7:0];
  assign unused_bits = ^{S_PADDR[31:8], S_PWDATA};

  always_comb begin
    mapped = 1'b1;
    ro     = 1'b0;
    unique case (addr)
      8'h00, 8'h08, 8'h18:        ro = 1'b0;
      8'h04, 8'h0C, 8'h10, 8'h14,
      8'h1C:                      ro = 1'b1;
      default:                    mapped = 1'b0;
    endcase
  end

  // A DATA_IN write is held off while a sort owns the scratch buffer.
  assign access    = S_PSEL & S_PENABLE;
  assign stall     = access & S_PWRITE & (addr == 8'h08) & (state_q != StIdle);
  assign xfer      = access & ~stall;
  assign err       = ~mapped | (S_PWRITE & ro);
  assign wr_ok     = xfer & S_PWRITE & ~err;
  assign S_PREADY  = xfer;
  assign S_PSLVERR = xfer & err;
  assign S_PRDATA  = (xfer & ~S_PWRITE & ~err) ? rdata : '0;
  assign IRQ       = irq_en_q & done_q;

  assign ctrl_wr    = wr_ok & (addr == 8'h00);
  assign data_wr    = wr_ok & (addr == 8'h08);
  assign w1c_wr     = wr_ok & (addr == 8'h18) & S_PWDATA[0];
  assign clr        = ctrl_wr & S_PWDATA[2];
  assign fill_post  = (fill_q == 8'(WIN_SIZE)) ? fill_q : fill_q + 8'd1;
  assign start_sort = data_wr & en_q & (fill_post == 8'(WIN_SIZE));
  assign last_pass  = (state_q == StSort) & (pass_q == PassW'(WIN_SIZE - 1)) & ~clr;
  assign done_d     = last_pass | (done_q & ~w1c_wr);

  always_comb begin
    for (int i = 0; i < int'(WIN_SIZE); i++) begin
      window_sh[i] = (i == int'(WIN_SIZE) - 1) ? S_PWDATA[SAMPLE_W-1:0] : window_q[i+1];
    end
  end

  // Pairs within one pass are disjoint, so all exchanges read the registered scratch.
  always_comb begin
    pass_out = scratch_q;
    for (int i = 0; i < int'(WIN_SIZE) - 1; i++) begin
      if ((i[0] == pass_q[0]) && (scratch_q[i] > scratch_q[i+1])) begin
        pass_out[i]   = scratch_q[i+1];
        pass_out[i+1] = scratch_q[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      8'h00:   rdata = BUS_WIDTH'({irq_en_q, en_q});
      8'h04:   rdata = BUS_WIDTH'({fill_q, 5'b0, done_q, valid_q, state_q == StSort});
      8'h08:   rdata = BUS_WIDTH'(window_q[WIN_SIZE-1]);
      8'h0C:   rdata = BUS_WIDTH'(median_q);
      8'h10:   rdata = BUS_WIDTH'(min_q);
      8'h14:   rdata = BUS_WIDTH'(max_q);
      8'h18:   rdata = BUS_WIDTH'(done_q);
      8'h1C:   rdata = BUS_WIDTH'({8'(WIN_SIZE), 8'(SAMPLE_W)});
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge S_CLK or posedge S_RST) begin
    if (S_RST) begin
      state_q   <= StIdle;
      window_q  <= '{default: '0};
      scratch_q <= '{default: '0};
      pass_q    <= '0;
      fill_q    <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      median_q  <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      done_q <= done_d;
      if (ctrl_wr) begin
        en_q     <= S_PWDATA[0];
        irq_en_q <= S_PWDATA[1];
      end
      if (clr) begin
        state_q  <= StIdle;
        window_q <= '{default: '0};
        fill_q   <= '0;
        valid_q  <= 1'b0;
      end else if (data_wr) begin
        window_q <= window_sh;
        fill_q   <= fill_post;
        if (start_sort) begin
          scratch_q <= window_sh;
          pass_q    <= '0;
          state_q   <= StSort;
        end
      end else if (state_q == StSort) begin
        scratch_q <= pass_out;
        pass_q    <= pass_q + 1'b1;
        if (last_pass) begin
          median_q <= pass_out[WIN_SIZE/2];
          min_q    <= pass_out[0];
          max_q    <= pass_out[WIN_SIZE-1];
          valid_q  <= 1'b1;
          state_q  <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_median_filter_stream.sv
// Self-checking bench for apb_median_filter_stream: register table, timing corner cases,
// then randomized traffic checked against a queue-and-sort reference model.
module tb_apb_median_filter_stream;

  localparam int W  = 9;
  localparam int SW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pready, pslverr, irq;
  logic [31:0] prdata;

  int n_vec = 0;
  int n_bad = 0;

  apb_median_filter_stream #(.BUS_WIDTH(32), .SAMPLE_W(SW), .WIN_SIZE(W)) dut (
    .S_CLK(clk), .S_RST(rst), .S_PSEL(psel), .S_PENABLE(penable), .S_PADDR(paddr),
    .S_PWRITE(pwrite), .S_PWDATA(pwdata), .S_PREADY(pready), .S_PSLVERR(pslverr),
    .S_PRDATA(prdata), .IRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer starting with SETUP now; returns #1 after the accepting edge.
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int stalls);
    logic got;
    got = 1'b0; stalls = 0; rd = '0; er = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (pready) begin
        got = 1'b1; rd = prdata; er = pslverr;
      end else begin
        stalls++;
      end
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL apb_timeout: addr 0x%08h got no PREADY, want PREADY within 100 cycles", a);
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic e; int s;
    apb(1'b1, a, d, r, e, s);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r; logic e; int s;
    apb(1'b0, a, 32'h0, r, e, s);
    chk(name, r, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: window as an array (oldest first), results from a plain sort.
  logic [SW-1:0] m_win [W];
  logic [7:0]    m_fill, m_med, m_min, m_max;
  logic          m_en, m_irqen, m_valid, m_done;

  task automatic m_reset();
    foreach (m_win[i]) m_win[i] = '0;
    m_fill = 0; m_med = 0; m_min = 0; m_max = 0;
    m_en = 0; m_irqen = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic m_data(input logic [31:0] d);
    int q[$];
    for (int i = 0; i < W - 1; i++) m_win[i] = m_win[i+1];
    m_win[W-1] = d[SW-1:0];
    if (m_fill < W) m_fill++;
    if (m_en && m_fill == W) begin
      foreach (m_win[i]) q.push_back(int'(m_win[i]));
      q.sort();
      m_med = 8'(q[W/2]); m_min = 8'(q[0]); m_max = 8'(q[W-1]);
      m_valid = 1; m_done = 1;
    end
    wr(32'h08, d);
    idle(W + 3);
  endtask

  task automatic m_ctrl(input logic [31:0] d);
    m_en = d[0]; m_irqen = d[1];
    if (d[2]) begin
      foreach (m_win[i]) m_win[i] = '0;
      m_fill = 0; m_valid = 0;
    end
    wr(32'h00, d);
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {30'b0, m_irqen, m_en};
      8'h04:   return {16'b0, m_fill, 5'b0, m_done, m_valid, 1'b0};
      8'h08:   return 32'(m_win[W-1]);
      8'h0C:   return 32'(m_med);
      8'h10:   return 32'(m_min);
      8'h14:   return 32'(m_max);
      8'h18:   return {31'b0, m_done};
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] r;
    logic        e;
    int          s;
    logic [7:0]  samples[W];
    logic [7:0]  raddrs[7];

    tbl[0]  = '{1'b0, 32'h1C,  32'h0,    1'b0, 32'h0908};
    tbl[1]  = '{1'b0, 32'h04,  32'h0,    1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h20,  32'h0,    1'b1, 32'h0};
    tbl[3]  = '{1'b1, 32'h04,  32'hFFFF, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h1C,  32'h1,    1'b1, 32'h0};
    tbl[5]  = '{1'b1, 32'h10,  32'h5,    1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h0C,  32'h0,    1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h00,  32'h3,    1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h00,  32'h0,    1'b0, 32'h3};
    tbl[9]  = '{1'b0, 32'h18,  32'h0,    1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h00,  32'h7,    1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h00,  32'h0,    1'b0, 32'h3};
    tbl[12] = '{1'b0, 32'hFC,  32'h0,    1'b1, 32'h0};
    tbl[13] = '{1'b0, 32'h100, 32'h0,    1'b0, 32'h3};

    samples = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
    raddrs  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};

    idle(3);
    chk("reset_pready", 32'(pready), 32'h0);
    chk("reset_pslverr", 32'(pslverr), 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    idle(2);

    foreach (tbl[i]) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, r, e, s);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rdata);
    end

    // Full window with EN: BUSY observed by back-to-back STATUS reads.
    foreach (samples[i]) wr(32'h08, 32'(samples[i]));
    for (int k = 0; k < 5; k++) begin
      rd_chk($sformatf("busy_poll%0d", k), 32'h04, (2 + 2 * k <= W) ? 32'h0901 : 32'h0906);
    end
    rd_chk("median1", 32'h0C, 32'd5);
    rd_chk("min1", 32'h10, 32'd1);
    rd_chk("max1", 32'h14, 32'd9);
    rd_chk("newest1", 32'h08, 32'd4);
    chk("irq_set", 32'(irq), 32'h1);
    wr(32'h18, 32'h1);
    chk("irq_w1c", 32'(irq), 32'h0);
    rd_chk("irqstat_clr", 32'h18, 32'h0);

    // Back-to-back DATA_IN: second write stalls until the first sort finishes.
    wr(32'h08, 32'hFF);
    apb(1'b1, 32'h08, 32'h03, r, e, s);
    chk("stall_cycles", 32'(s), 32'(W - 1));
    rd_chk("median2", 32'h0C, 32'd6);
    rd_chk("min2", 32'h10, 32'd1);
    rd_chk("max2", 32'h14, 32'd255);
    idle(W + 3);
    rd_chk("median3", 32'h0C, 32'd6);
    rd_chk("min3", 32'h10, 32'd2);

    apb(1'b1, 32'h0C, 32'h55, r, e, s);
    chk("ro_write_err", 32'(e), 32'h1);
    rd_chk("median_kept", 32'h0C, 32'd6);
    apb(1'b0, 32'h20, 32'h0, r, e, s);
    chk("unmapped_err", 32'(e), 32'h1);
    chk("unmapped_rdata", r, 32'h0);

    // W1C issued on the same edge as sort completion: DONE stays set.
    wr(32'h18, 32'h1);
    wr(32'h08, 32'h01);
    idle(W - 2);
    wr(32'h18, 32'h1);
    rd_chk("done_set_wins", 32'h18, 32'h1);
    rd_chk("median4", 32'h0C, 32'd4);

    // CLR during pass 3 aborts the sort and keeps the old results.
    wr(32'h08, 32'h80);
    idle(2);
    wr(32'h00, 32'h7);
    rd_chk("clr_status", 32'h04, 32'h0004);
    idle(W + 3);
    rd_chk("clr_median", 32'h0C, 32'd4);
    rd_chk("clr_min", 32'h10, 32'd1);
    rd_chk("clr_max", 32'h14, 32'd255);
    rd_chk("clr_ctrl", 32'h00, 32'h3);
    repeat (W) wr(32'h08, 32'h42);
    idle(W + 3);
    rd_chk("median42", 32'h0C, 32'h42);
    rd_chk("min42", 32'h10, 32'h42);
    rd_chk("max42", 32'h14, 32'h42);

    // Asynchronous reset mid-sort.
    chk("irq_before_rst", 32'(irq), 32'h1);
    wr(32'h08, 32'h10);
    idle(3);
    #2 rst = 1'b1;
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    rd_chk("rst_status", 32'h04, 32'h0);
    rd_chk("rst_median", 32'h0C, 32'h0);
    rd_chk("rst_ctrl", 32'h00, 32'h0);

    // From here on expectations come from the reference model.
    m_reset();
    for (int i = 0; i < W; i++) m_data($urandom);
    chk("en0_status", m_read(8'h04), 32'h0900);
    rd_chk("en0_status_dut", 32'h04, m_read(8'h04));

    m_ctrl(32'h3);
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 9) begin
        m_data($urandom);
      end else if (op == 9) begin
        m_ctrl({29'b0, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))});
      end else if (op == 10) begin
        logic [31:0] v;
        v = 32'($urandom_range(0, 1));
        if (v[0]) m_done = 0;
        wr(32'h18, v);
      end else begin
        logic [7:0] a;
        a = raddrs[$urandom_range(0, 6)];
        rd_chk($sformatf("rand%0d_a%02h", n, a), 32'(a), m_read(a));
      end
      chk($sformatf("rand%0d_irq", n), 32'(irq), 32'(m_irqen & m_done));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
